// File: rtl/sram_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_access_arbiter                                        |
// | Description : Round-robin sharing of one SRAM controller port among      |
// |               NUM_REQ requesters, with burst lock and read-data routing. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sram_access_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int READ_LATENCY = 2
) (
    input  logic                     Clock_50,
    input  logic                     Resetn,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       lock_i,
    input  logic [NUM_REQ-1:0]       we_n_i,
    input  logic [NUM_REQ-1:0][17:0] addr_i,
    input  logic [NUM_REQ-1:0][15:0] wdata_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       rvalid_o,
    output logic [15:0]              rdata_o,
    output logic [17:0]              SRAM_address_o,
    output logic [15:0]              SRAM_write_data_o,
    output logic                     SRAM_we_n_o,
    input  logic [15:0]              SRAM_read_data_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [0:0] S_ARB_IDLE  = 1'b0;
    localparam logic [0:0] S_ARB_OWNED = 1'b1;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic [IDX_W-1:0]   r_last_owner;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic               w_keep;
    logic               w_issue;
    logic               w_issue_rd;

    logic [READ_LATENCY-1:0]            r_tag_valid;
    logic [READ_LATENCY-1:0][IDX_W-1:0] r_tag_owner;

    // Scan offsets high-to-low so the smallest offset after last_owner wins;
    // offset NUM_REQ lands on last_owner itself, giving it lowest priority.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_pick  = r_last_owner;
        for (int i = NUM_REQ; i >= 1; i--) begin
            v_idx = int'(r_last_owner) + i;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (req_i[IDX_W'(v_idx)]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_keep      = (r_state == S_ARB_OWNED) && req_i[r_owner] && lock_i[r_owner];
        if (!w_keep) begin
            if (w_found) begin
                w_state_nxt = S_ARB_OWNED;
                w_owner_nxt = w_pick;
                w_last_nxt  = w_pick;
            end else begin
                w_state_nxt = S_ARB_IDLE;
            end
        end
        w_grant_nxt = (w_state_nxt == S_ARB_OWNED) ? (NUM_REQ'(1) << w_owner_nxt) : '0;
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state      <= S_ARB_IDLE;
            r_owner      <= '0;
            r_last_owner <= c_last_idx;
            r_grant      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_grant      <= w_grant_nxt;
        end
    end

    assign grant_o    = r_grant;
    assign w_issue    = |(r_grant & req_i);
    assign w_issue_rd = w_issue && we_n_i[r_owner];

    // Outputs are forced to a benign read of address 0 when nothing is issued.
    always_comb begin
        SRAM_address_o    = '0;
        SRAM_write_data_o = '0;
        SRAM_we_n_o       = 1'b1;
        if (w_issue) begin
            SRAM_address_o    = addr_i[r_owner];
            SRAM_write_data_o = wdata_i[r_owner];
            SRAM_we_n_o       = we_n_i[r_owner];
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_tag_valid <= '0;
            r_tag_owner <= '0;
        end else begin
            r_tag_valid[0] <= w_issue_rd;
            r_tag_owner[0] <= r_owner;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_tag_valid[s] <= r_tag_valid[s-1];
                r_tag_owner[s] <= r_tag_owner[s-1];
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_rvalid
        assign rvalid_o[k] = r_tag_valid[READ_LATENCY-1] &&
                             (r_tag_owner[READ_LATENCY-1] == IDX_W'(k));
    end

    assign rdata_o = SRAM_read_data_i;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sram_access_arbiter                                     |
// | Description : Scoreboard bench for sram_access_arbiter with SRAM model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sram_access_arbiter;

    localparam int NUM_REQ = 3;
    localparam int LAT     = 2;

    logic                     Clock_50 = 1'b0;
    logic                     Resetn;
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ-1:0]       lock_i;
    logic [NUM_REQ-1:0]       we_n_i;
    logic [NUM_REQ-1:0][17:0] addr_i;
    logic [NUM_REQ-1:0][15:0] wdata_i;
    logic [NUM_REQ-1:0]       grant_o;
    logic [NUM_REQ-1:0]       rvalid_o;
    logic [15:0]              rdata_o;
    logic [17:0]              SRAM_address_o;
    logic [15:0]              SRAM_write_data_o;
    logic                     SRAM_we_n_o;
    logic [15:0]              SRAM_read_data_i;

    sram_access_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .READ_LATENCY (LAT)
    ) dut (
        .Clock_50          (Clock_50),
        .Resetn            (Resetn),
        .req_i             (req_i),
        .lock_i            (lock_i),
        .we_n_i            (we_n_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .grant_o           (grant_o),
        .rvalid_o          (rvalid_o),
        .rdata_o           (rdata_o),
        .SRAM_address_o    (SRAM_address_o),
        .SRAM_write_data_o (SRAM_write_data_o),
        .SRAM_we_n_o       (SRAM_we_n_o),
        .SRAM_read_data_i  (SRAM_read_data_i)
    );

    always #5 Clock_50 = ~Clock_50;

    // SRAM controller model: fixed two-cycle read pipeline
    logic [15:0]  mem [0:1023];
    bit   [1023:0] written;
    logic [15:0]  rd_p0;
    logic [15:0]  rd_p1;

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        return written[a[9:0]] ? mem[a[9:0]] : (a[15:0] ^ 16'hC3A5);
    endfunction

    always @(posedge Clock_50) begin
        if (!SRAM_we_n_o) begin
            mem[SRAM_address_o[9:0]]     <= SRAM_write_data_o;
            written[SRAM_address_o[9:0]] <= 1'b1;
        end
        rd_p0 <= mem_rd(SRAM_address_o);
        rd_p1 <= rd_p0;
    end
    assign SRAM_read_data_i = rd_p1;

    typedef struct {
        int          due;
        int          who;
        logic [15:0] data;
    } rd_exp_t;

    rd_exp_t     sb[$];
    int          iss_log[$];
    int          cyc_log[$];
    int          n_chk;
    int          n_err;
    int          cyc;
    int          last_who;
    int          n_wr;
    logic [2:0]  g_smp;

    int          n_left   [NUM_REQ];
    logic [17:0] cur_addr [NUM_REQ];
    logic        wen      [NUM_REQ];
    logic [15:0] wd       [NUM_REQ];
    logic        lk       [NUM_REQ];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_i[k]   = (n_left[k] > 0);
            lock_i[k]  = lk[k];
            we_n_i[k]  = wen[k];
            addr_i[k]  = cur_addr[k];
            wdata_i[k] = wd[k];
        end
    endtask

    task automatic start(input int k, input logic [17:0] a, input int n,
                         input logic w, input logic [15:0] d, input logic l);
        n_left[k]   = n;
        cur_addr[k] = a;
        wen[k]      = w;
        wd[k]       = d;
        lk[k]       = l;
        drive();
    endtask

    task automatic clear_jobs();
        for (int k = 0; k < NUM_REQ; k++) begin
            n_left[k]   = 0;
            cur_addr[k] = '0;
            wen[k]      = 1'b1;
            wd[k]       = '0;
            lk[k]       = 1'b0;
        end
        drive();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_grant"},  grant_o,           0);
        check({tag, "_rvalid"}, rvalid_o,          0);
        check({tag, "_we_n"},   SRAM_we_n_o,       1);
        check({tag, "_addr"},   SRAM_address_o,    0);
        check({tag, "_wdata"},  SRAM_write_data_o, 0);
    endtask

    // One clock cycle: sample mid-cycle, score returns, track issues, then drive.
    task automatic step();
        logic [2:0]  exp_rv;
        logic [2:0]  iss;
        logic [15:0] exp_d;
        rd_exp_t     e;
        int          k;
        @(negedge Clock_50);
        cyc++;
        exp_rv = '0;
        exp_d  = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            exp_rv[e.who] = 1'b1;
            exp_d = e.data;
        end
        check("rvalid", rvalid_o, exp_rv);
        if (exp_rv != 0) check("rdata", rdata_o, exp_d);
        g_smp = grant_o;
        check("grant_onehot", $onehot0(grant_o), 1);
        if (!SRAM_we_n_o) n_wr++;
        iss      = grant_o & req_i;
        last_who = -1;
        if (iss == 0) begin
            check("idle_we_n", SRAM_we_n_o,    1);
            check("idle_addr", SRAM_address_o, 0);
        end else begin
            k = iss[0] ? 0 : (iss[1] ? 1 : 2);
            last_who = k;
            check("issue_addr", SRAM_address_o, cur_addr[k]);
            check("issue_we_n", SRAM_we_n_o,    wen[k]);
            if (!wen[k]) check("issue_wdata", SRAM_write_data_o, wd[k]);
            if (wen[k]) sb.push_back('{cyc + LAT, k, mem_rd(cur_addr[k])});
            iss_log.push_back(k);
            cyc_log.push_back(cyc);
            cur_addr[k] = cur_addr[k] + 18'd1;
            n_left[k]--;
        end
        @(posedge Clock_50);
        #1;
        drive();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal;
    end

    initial begin
        int exp2 [5];
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        n_wr  = 0;
        clear_jobs();
        Resetn = 1'b1;
        #2 Resetn = 1'b0;
        @(negedge Clock_50);
        check_reset("rst0");
        @(posedge Clock_50);
        #1 Resetn = 1'b1;

        // single read from idle
        start(1, 18'h00100, 1, 1'b1, 16'h0, 1'b0);
        step();
        check("t1_no_grant_yet", g_smp, 0);
        step();
        check("t1_grant", g_smp, 3'b010);
        check("t1_issue_who", last_who, 1);
        repeat (3) step();

        // unlocked contention alternates
        iss_log.delete();
        start(0, 18'h00200, 3, 1'b1, 16'h0, 1'b0);
        start(1, 18'h00300, 2, 1'b1, 16'h0, 1'b0);
        repeat (8) step();
        exp2 = '{0, 1, 0, 1, 0};
        check("t2_count", iss_log.size(), 5);
        for (int i = 0; i < 5 && i < iss_log.size(); i++) check("t2_order", iss_log[i], exp2[i]);

        // locked burst holds off a waiting requester
        iss_log.delete();
        cyc_log.delete();
        start(0, 18'h00000, 4, 1'b1, 16'h0, 1'b1);
        step();
        start(2, 18'h00040, 1, 1'b1, 16'h0, 1'b0);
        repeat (8) step();
        lk[0] = 1'b0;
        check("t3_count", iss_log.size(), 5);
        if (iss_log.size() == 5) begin
            for (int i = 0; i < 4; i++) check("t3_burst_owner", iss_log[i], 0);
            for (int i = 1; i < 4; i++) check("t3_burst_gap", cyc_log[i] - cyc_log[i-1], 1);
            check("t3_waiter_owner", iss_log[4], 2);
            check("t3_waiter_delay", cyc_log[4] - cyc_log[3], 2);
        end

        // single write
        iss_log.delete();
        n_wr = 0;
        start(2, 18'h12C00, 1, 1'b0, 16'hABCD, 1'b0);
        repeat (5) step();
        check("t4_count", iss_log.size(), 1);
        if (iss_log.size() == 1) check("t4_who", iss_log[0], 2);
        check("t4_we_pulses", n_wr, 1);
        check("t4_mem", mem[10'h000], 16'hABCD);

        // reset right after a read issue discards it
        iss_log.delete();
        start(1, 18'h00500, 1, 1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 5 && iss_log.size() == 0; i++) step();
        check("t5_issued", iss_log.size(), 1);
        Resetn = 1'b0;
        sb.delete();
        clear_jobs();
        #1;
        check_reset("t5_rst");
        repeat (3) begin
            step();
            check("t5_grant_in_rst", g_smp, 0);
        end
        Resetn = 1'b1;
        repeat (4) step();

        // quiet bus
        repeat (10) begin
            step();
            check("t6_grant", g_smp, 0);
        end

        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
